// File: rtl/ahb_pkg.sv
// Shared AHB-Lite encodings and the response payload carried from the bus back to the command source.
package ahb_pkg;

  localparam int unsigned AHB_DATA_W = 32;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [1:0] HRESP_OKAY  = 2'b00;
  localparam logic [1:0] HRESP_ERROR = 2'b01;
  localparam logic [1:0] HRESP_RETRY = 2'b10;
  localparam logic [1:0] HRESP_SPLIT = 2'b11;

  localparam logic [2:0] HSIZE_WORD = 3'b010;

  typedef struct packed {
    logic [AHB_DATA_W-1:0] rdata;
    logic                  err;
  } rsp_t;

endpackage

// File: rtl/ahb_rsp_fifo.sv
// Response FIFO: power-of-two depth, simultaneous push/pop, pops on empty are ignored.
module ahb_rsp_fifo
  import ahb_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                     HCLK,
  input  logic                     HRESETn,
  input  logic                     push_i,
  input  rsp_t                     push_data_i,
  input  logic                     pop_i,
  output rsp_t                     head_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     full_o,
  output logic                     empty_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  rsp_t             mem_q [DEPTH];
  logic [PTR_W-1:0] wptr_q, rptr_q;
  logic [CNT_W-1:0] count_q;
  logic             pop_ok;

  assign pop_ok  = pop_i && (count_q != '0);
  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign head_o  = mem_q[rptr_q];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (push_i) begin
        mem_q[wptr_q] <= push_data_i;
        wptr_q        <= wptr_q + PTR_W'(1);
      end
      if (pop_ok) rptr_q <= rptr_q + PTR_W'(1);
      case ({push_i, pop_ok})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/ahb_cmd_master.sv
// AHB-Lite single-transfer master: valid/ready commands in, pipelined NONSEQ word transfers out,
// one response per command returned through a credit-protected FIFO.
module ahb_cmd_master
  import ahb_pkg::*;
#(
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned RSP_DEPTH = 4
) (
  input  logic              HCLK,
  input  logic              HRESETn,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic [ADDR_W-1:0] HADDR,
  output logic [1:0]        HTRANS,
  output logic              HWRITE,
  output logic [2:0]        HSIZE,
  output logic [DATA_W-1:0] HWDATA,
  input  logic              HREADY,
  input  logic [1:0]        HRESP,
  input  logic [DATA_W-1:0] HRDATA,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err
);

  localparam int unsigned CNT_W = $clog2(RSP_DEPTH) + 1;
  localparam int unsigned SUM_W = CNT_W + 1;

  logic              a_valid_q, a_valid_d;
  logic [ADDR_W-1:0] a_addr_q,  a_addr_d;
  logic              a_write_q, a_write_d;
  logic [DATA_W-1:0] a_wdata_q, a_wdata_d;
  logic              d_valid_q, d_valid_d;
  logic              d_write_q, d_write_d;
  logic [DATA_W-1:0] d_wdata_q, d_wdata_d;
  logic              cancel_q,  cancel_d;
  logic [1:0]        htrans_q,  htrans_d;

  logic             hresp_err, err1, a_done, d_done, accept, credit_ok;
  logic [SUM_W-1:0] in_flight;
  logic [CNT_W-1:0] fifo_count;
  logic             fifo_full, fifo_empty;
  rsp_t             push_data, fifo_head;

  assign hresp_err = (HRESP != HRESP_OKAY);
  assign err1      = d_valid_q && !HREADY && hresp_err;
  // While the cancelled address is off the bus (cancel_q), A must not be treated as accepted by the slave.
  assign a_done    = a_valid_q && HREADY && !err1 && !cancel_q;
  assign d_done    = d_valid_q && HREADY;

  // Every command holds a response credit from acceptance until its response is popped.
  assign in_flight = SUM_W'(fifo_count) + SUM_W'(a_valid_q) + SUM_W'(d_valid_q);
  assign credit_ok = in_flight < SUM_W'(RSP_DEPTH);
  // Combinational from HREADY/HRESP so a zero-wait slave sustains one command per cycle.
  assign cmd_ready = (!a_valid_q || a_done) && credit_ok;
  assign accept    = cmd_valid && cmd_ready;

  always_comb begin
    a_valid_d = a_valid_q;
    a_addr_d  = a_addr_q;
    a_write_d = a_write_q;
    a_wdata_d = a_wdata_q;
    d_valid_d = d_valid_q;
    d_write_d = d_write_q;
    d_wdata_d = d_wdata_q;
    cancel_d  = cancel_q;

    if (d_done) d_valid_d = 1'b0;
    if (a_done) begin
      d_valid_d = 1'b1;
      d_write_d = a_write_q;
      d_wdata_d = a_wdata_q;
      a_valid_d = 1'b0;
    end
    if (accept) begin
      a_valid_d = 1'b1;
      a_addr_d  = cmd_addr;
      a_write_d = cmd_write;
      a_wdata_d = cmd_wdata;
    end

    if (err1)        cancel_d = 1'b1;
    else if (d_done) cancel_d = 1'b0;

    htrans_d = (a_valid_d && !cancel_d) ? HTRANS_NONSEQ : HTRANS_IDLE;
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      a_valid_q <= 1'b0;
      a_addr_q  <= '0;
      a_write_q <= 1'b0;
      a_wdata_q <= '0;
      d_valid_q <= 1'b0;
      d_write_q <= 1'b0;
      d_wdata_q <= '0;
      cancel_q  <= 1'b0;
      htrans_q  <= HTRANS_IDLE;
    end else begin
      a_valid_q <= a_valid_d;
      a_addr_q  <= a_addr_d;
      a_write_q <= a_write_d;
      a_wdata_q <= a_wdata_d;
      d_valid_q <= d_valid_d;
      d_write_q <= d_write_d;
      d_wdata_q <= d_wdata_d;
      cancel_q  <= cancel_d;
      htrans_q  <= htrans_d;
    end
  end

  assign HADDR  = a_addr_q;
  assign HWRITE = a_write_q;
  assign HTRANS = htrans_q;
  assign HSIZE  = HSIZE_WORD;
  assign HWDATA = d_wdata_q;

  always_comb begin
    push_data.err   = hresp_err;
    push_data.rdata = (d_write_q || hresp_err) ? '0 : AHB_DATA_W'(HRDATA);
  end

  ahb_rsp_fifo #(.DEPTH(RSP_DEPTH)) u_rsp_fifo (
    .HCLK       (HCLK),
    .HRESETn    (HRESETn),
    .push_i     (d_done),
    .push_data_i(push_data),
    .pop_i      (rsp_ready),
    .head_o     (fifo_head),
    .count_o    (fifo_count),
    .full_o     (fifo_full),
    .empty_o    (fifo_empty)
  );

  assign rsp_valid = !fifo_empty;
  assign rsp_rdata = rsp_valid ? DATA_W'(fifo_head.rdata) : '0;
  assign rsp_err   = rsp_valid && fifo_head.err;

  // The credit rule makes a push into a full FIFO unreachable.
  assert property (@(posedge HCLK) disable iff (!HRESETn) !(d_done && fifo_full))
    else $error("ahb_cmd_master: response FIFO overflow");

endmodule

// File: tb/tb_ahb_cmd_master.sv
// Bench for ahb_cmd_master: behavioural AHB slave, in-order response scoreboard, directed and random scenarios.
module tb_ahb_cmd_master;
  import ahb_pkg::*;

  logic        HCLK = 1'b0;
  logic        HRESETn;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [31:0] cmd_addr, cmd_wdata;
  logic [31:0] HADDR, HWDATA, HRDATA;
  logic [1:0]  HTRANS, HRESP;
  logic        HWRITE, HREADY;
  logic [2:0]  HSIZE;
  logic        rsp_valid, rsp_ready, rsp_err;
  logic [31:0] rsp_rdata;

  always #5 HCLK = ~HCLK;

  ahb_cmd_master #(.ADDR_W(32), .DATA_W(32), .RSP_DEPTH(4)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE), .HWDATA(HWDATA),
    .HREADY(HREADY), .HRESP(HRESP), .HRDATA(HRDATA),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  always @(posedge HCLK) cyc++;

  typedef struct { logic [31:0] rdata; logic err; int acc; } exp_t;
  typedef struct { logic [31:0] rdata; logic err; } rsp_rec_t;
  exp_t     exp_q[$];
  rsp_rec_t rsp_log[$];
  int       lat_q[$];
  int       acc_log[$];
  logic [31:0] smem [32];
  logic [31:0] refmem [32];
  int nonseq_cnt = 0, stall_cnt = 0, hold_cnt = 0, cancel_cnt = 0;

  // Slave configuration
  int          max_wait = 0, wr_wait_once = 0;
  bit          err_match_en = 0, rand_err_en = 0, rsp_rand = 0;
  logic [31:0] err_addr = '0, last_wr_data = '0;

  function automatic bit is_err(input logic [31:0] a);
    return (err_match_en && a == err_addr) || (rand_err_en && a[6] && a[2]);
  endfunction

  // Behavioural slave: decides at the negedge, drives just after the next posedge.
  bit          dp_valid = 0, dp_write = 0, dp_err = 0, err_phase = 0;
  logic [31:0] dp_addr = '0;
  int          dp_wait = 0;
  always @(negedge HCLK) begin
    if (!HRESETn) begin
      dp_valid = 0; dp_wait = 0; err_phase = 0;
    end else if (HREADY) begin
      if (dp_valid && !dp_err && dp_write) begin
        smem[dp_addr[6:2]] = HWDATA;
        last_wr_data = HWDATA;
      end
      dp_valid  = (HTRANS == HTRANS_NONSEQ);
      dp_addr   = HADDR;
      dp_write  = HWRITE;
      dp_err    = is_err(HADDR);
      err_phase = 0;
      if (dp_valid && HWRITE && wr_wait_once > 0) begin
        dp_wait = wr_wait_once; wr_wait_once = 0;
      end else begin
        dp_wait = (max_wait > 0) ? int'($urandom_range(max_wait, 0)) : 0;
      end
    end else if (dp_wait > 0) begin
      dp_wait--;
    end else if (dp_err) begin
      err_phase = 1;
    end
    @(posedge HCLK);
    #1;
    HRDATA = $urandom;
    if (!HRESETn || !dp_valid) begin
      HREADY = 1'b1; HRESP = HRESP_OKAY;
    end else if (dp_wait > 0) begin
      HREADY = 1'b0; HRESP = HRESP_OKAY;
    end else if (dp_err) begin
      HREADY = err_phase; HRESP = HRESP_ERROR;
    end else begin
      HREADY = 1'b1; HRESP = HRESP_OKAY;
      if (!dp_write) HRDATA = smem[dp_addr[6:2]];
    end
  end

  always @(posedge HCLK) begin
    #1;
    if (rsp_rand) rsp_ready = ($urandom_range(3, 0) != 0);
  end

  // Monitor + reference model: expected response fixed at acceptance, in command order.
  bit          p_valid = 0, p_hready = 1, p_hwrite = 0;
  logic [1:0]  p_hresp = '0, p_htrans = '0;
  logic [31:0] p_haddr = '0, p_hwdata = '0;
  always @(negedge HCLK) begin
    if (!HRESETn) begin
      exp_q.delete();
      p_valid = 0;
    end else begin
      if (p_valid && !p_hready && p_hresp == HRESP_OKAY && p_htrans == HTRANS_NONSEQ) begin
        total++; hold_cnt++;
        if (HADDR !== p_haddr || HTRANS !== p_htrans || HWRITE !== p_hwrite || HWDATA !== p_hwdata) begin
          bad++;
          $display("FAIL wait_hold t=%0t got addr=%h trans=%b wdata=%h exp addr=%h trans=%b wdata=%h",
                   $time, HADDR, HTRANS, HWDATA, p_haddr, p_htrans, p_hwdata);
        end
      end
      if (p_valid && !p_hready && p_hresp != HRESP_OKAY) begin
        total++; cancel_cnt++;
        if (HTRANS !== HTRANS_IDLE) begin
          bad++; $display("FAIL err_cancel t=%0t got HTRANS=%b exp=00", $time, HTRANS);
        end
      end
      if (HTRANS == HTRANS_NONSEQ) begin
        nonseq_cnt++;
        total++;
        if (HSIZE !== 3'b010) begin
          bad++; $display("FAIL hsize got=%b exp=010", HSIZE);
        end
      end
      if (cmd_valid && !cmd_ready) stall_cnt++;
      if (cmd_valid && cmd_ready) begin
        exp_t e;
        e.err   = is_err(cmd_addr);
        e.rdata = (cmd_write || e.err) ? 32'h0 : refmem[cmd_addr[6:2]];
        e.acc   = cyc;
        if (cmd_write && !e.err) refmem[cmd_addr[6:2]] = cmd_wdata;
        exp_q.push_back(e);
        acc_log.push_back(cyc);
      end
      if (rsp_valid && rsp_ready) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++; $display("FAIL rsp_extra got rdata=%h err=%b exp none", rsp_rdata, rsp_err);
        end else begin
          exp_t e;
          rsp_rec_t r;
          e = exp_q.pop_front();
          if (rsp_rdata !== e.rdata || rsp_err !== e.err) begin
            bad++; $display("FAIL rsp_data got rdata=%h err=%b exp rdata=%h err=%b",
                            rsp_rdata, rsp_err, e.rdata, e.err);
          end
          r.rdata = rsp_rdata; r.err = rsp_err;
          rsp_log.push_back(r);
          lat_q.push_back(cyc - e.acc);
        end
      end
      p_valid = 1; p_hready = HREADY; p_hresp = HRESP; p_htrans = HTRANS;
      p_haddr = HADDR; p_hwrite = HWRITE; p_hwdata = HWDATA;
    end
  end

  task automatic issue(input logic w, input logic [31:0] a, input logic [31:0] d);
    int n = 0;
    cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_wdata = d;
    forever begin
      @(negedge HCLK);
      if (cmd_ready) break;
      n++;
      if (n > 300) begin
        total++; bad++;
        $display("FAIL issue_timeout addr=%h got no cmd_ready exp accept", a);
        break;
      end
      @(posedge HCLK); #1;
    end
    @(posedge HCLK); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n = 0;
    while ((exp_q.size() != 0 || rsp_valid) && n < 500) begin
      @(posedge HCLK); #1; n++;
    end
    total++;
    if (n >= 500) begin
      bad++; $display("FAIL drain_timeout got pending=%0d exp 0", exp_q.size());
    end
  endtask

  task automatic check_int(input string name, input int got, input int expv);
    total++;
    if (got != expv) begin
      bad++; $display("FAIL %s got=%0d exp=%0d", name, got, expv);
    end
  endtask

  task automatic test_reset();
    HRESETn = 1'b0; cmd_valid = 0; cmd_write = 0; cmd_addr = '0; cmd_wdata = '0;
    rsp_ready = 1'b1; HREADY = 1'b1; HRESP = HRESP_OKAY; HRDATA = '0;
    repeat (3) @(posedge HCLK);
    #1;
    total++;
    if (HTRANS !== 2'b00 || HADDR !== 32'h0 || HWRITE !== 1'b0 || HWDATA !== 32'h0) begin
      bad++; $display("FAIL reset_bus got trans=%b addr=%h write=%b wdata=%h exp 0", HTRANS, HADDR, HWRITE, HWDATA);
    end
    total++;
    if (rsp_valid !== 1'b0 || rsp_rdata !== 32'h0 || rsp_err !== 1'b0) begin
      bad++; $display("FAIL reset_rsp got valid=%b rdata=%h err=%b exp 0", rsp_valid, rsp_rdata, rsp_err);
    end
    @(negedge HCLK); HRESETn = 1'b1;
    @(posedge HCLK); #1;
    total++;
    if (cmd_ready !== 1'b1) begin
      bad++; $display("FAIL reset_ready got=%b exp=1", cmd_ready);
    end
  endtask

  task automatic test_write_read();
    int a0 = acc_log.size(), r0 = lat_q.size(), ns0 = nonseq_cnt;
    issue(1'b1, 32'h0, 32'hDEADBEEF);
    issue(1'b0, 32'h0, 32'h0);
    wait_drain();
    check_int("wr_accept_gap", acc_log[a0+1] - acc_log[a0], 1);
    check_int("wr_nonseq", nonseq_cnt - ns0, 2);
    check_int("wr_rsp_count", lat_q.size() - r0, 2);
    if (lat_q.size() >= r0 + 2) begin
      check_int("wr_lat_w", lat_q[r0], 3);
      check_int("wr_lat_r", lat_q[r0+1], 3);
      check_int("wr_read_data", (rsp_log[r0+1].rdata == 32'hDEADBEEF) ? 1 : 0, 1);
    end
    check_int("wr_hwdata", (last_wr_data == 32'hDEADBEEF) ? 1 : 0, 1);
  endtask

  task automatic test_back_to_back();
    int a0 = acc_log.size(), r0 = lat_q.size(), ns0 = nonseq_cnt, st0 = stall_cnt;
    for (int i = 0; i < 8; i++) issue(1'b0, {25'h0, 5'($urandom_range(31, 0)), 2'b00}, 32'h0);
    wait_drain();
    check_int("b2b_nonseq", nonseq_cnt - ns0, 8);
    check_int("b2b_stall", stall_cnt - st0, 0);
    check_int("b2b_span", acc_log[a0+7] - acc_log[a0], 7);
    check_int("b2b_rsp_count", lat_q.size() - r0, 8);
    for (int i = r0; i < lat_q.size(); i++) check_int("b2b_lat", lat_q[i], 3);
  endtask

  task automatic test_wait_states();
    int r0 = lat_q.size(), h0 = hold_cnt;
    wr_wait_once = 3;
    issue(1'b1, 32'h20, $urandom);
    issue(1'b0, 32'h24, 32'h0);
    wait_drain();
    check_int("ws_hold_cycles", hold_cnt - h0, 3);
    check_int("ws_rsp_count", lat_q.size() - r0, 2);
    if (lat_q.size() >= r0 + 2) begin
      check_int("ws_lat_w", lat_q[r0], 6);
      check_int("ws_lat_r", lat_q[r0+1], 6);
    end
  endtask

  task automatic test_error();
    int r0 = lat_q.size(), ns0 = nonseq_cnt, c0 = cancel_cnt;
    err_match_en = 1; err_addr = 32'h10;
    issue(1'b0, 32'h10, 32'h0);
    issue(1'b1, 32'h14, 32'h600DF00D);
    wait_drain();
    check_int("err_rsp_count", lat_q.size() - r0, 2);
    check_int("err_nonseq", nonseq_cnt - ns0, 3);
    check_int("err_cancel_seen", cancel_cnt - c0, 1);
    if (lat_q.size() >= r0 + 2) begin
      check_int("err_flag_r", int'(rsp_log[r0].err), 1);
      check_int("err_flag_w", int'(rsp_log[r0+1].err), 0);
      check_int("err_lat_r", lat_q[r0], 4);
      check_int("err_lat_w", lat_q[r0+1], 5);
    end
    err_match_en = 0;
    issue(1'b0, 32'h14, 32'h0);
    wait_drain();
    check_int("err_write_landed", (last_wr_data == 32'h600DF00D) ? 1 : 0, 1);
  endtask

  task automatic test_backpressure();
    int a0 = acc_log.size(), r0 = lat_q.size(), ns0, rdy_seen = 0;
    rsp_ready = 1'b0;
    for (int i = 0; i < 4; i++) issue(i[0], {25'h0, 5'(i + 8), 2'b00}, $urandom);
    repeat (4) @(posedge HCLK);
    #1;
    ns0 = nonseq_cnt;
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h30; cmd_wdata = '0;
    for (int i = 0; i < 10; i++) begin
      @(negedge HCLK);
      if (cmd_ready) rdy_seen++;
      @(posedge HCLK); #1;
    end
    check_int("bp_ready_blocked", rdy_seen, 0);
    check_int("bp_accepted", acc_log.size() - a0, 4);
    check_int("bp_bus_idle", nonseq_cnt - ns0, 0);
    check_int("bp_rsp_valid", int'(rsp_valid), 1);
    rsp_ready = 1'b1;
    issue(1'b0, 32'h30, 32'h0);
    issue(1'b1, 32'h34, $urandom);
    wait_drain();
    check_int("bp_rsp_count", lat_q.size() - r0, 6);
  endtask

  task automatic test_reset_mid();
    int r0;
    rsp_ready = 1'b1;
    wr_wait_once = 3;
    issue(1'b1, 32'h38, 32'hA5A55A5A);
    issue(1'b0, 32'h3C, 32'h0);
    r0 = lat_q.size();
    #2 HRESETn = 1'b0;
    #1;
    total++;
    if (HTRANS !== 2'b00 || HADDR !== 32'h0 || HWDATA !== 32'h0 || HWRITE !== 1'b0 || rsp_valid !== 1'b0) begin
      bad++; $display("FAIL rst_mid_async got trans=%b addr=%h wdata=%h write=%b rvalid=%b exp 0",
                      HTRANS, HADDR, HWDATA, HWRITE, rsp_valid);
    end
    @(negedge HCLK); @(negedge HCLK);
    HRESETn = 1'b1;
    wr_wait_once = 0;
    for (int i = 0; i < 32; i++) refmem[i] = smem[i];
    repeat (6) @(posedge HCLK);
    #1;
    check_int("rst_mid_no_rsp", lat_q.size() - r0, 0);
    issue(1'b0, 32'h38, 32'h0);
    wait_drain();
    check_int("rst_mid_fresh", lat_q.size() - r0, 1);
  endtask

  task automatic test_random();
    int r0 = lat_q.size();
    rsp_rand = 1; rand_err_en = 1; max_wait = 2;
    for (int i = 0; i < 150; i++) begin
      if ($urandom_range(3, 0) == 0) begin
        @(posedge HCLK); #1;
      end
      issue(1'($urandom_range(1, 0)), {25'h0, 5'($urandom_range(31, 0)), 2'b00}, $urandom);
    end
    rsp_rand = 0; rsp_ready = 1'b1;
    wait_drain();
    check_int("rand_rsp_count", lat_q.size() - r0, 150);
    rand_err_en = 0; max_wait = 0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired at t=%0t exp finish", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 32; i++) begin
      smem[i]   = $urandom;
      refmem[i] = smem[i];
    end
    test_reset();
    test_write_read();
    test_back_to_back();
    test_wait_states();
    test_error();
    test_backpressure();
    test_reset_mid();
    test_random();
    repeat (3) @(posedge HCLK);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
